// File: rtl/clk_tick_gen_if.sv
// clk_tick_gen_if: control/status bundle for the multi-channel tick generator.
//   en, sync       per-channel count enable / synchronous phase clear
//   div_wr/sel/data divisor write strobe, channel index, new divisor
//   clk_out, tick  divided clocks and one-cycle tick enables
//   pending        shadow divisor waiting to be committed
// master = controller side, slave = clk_tick_gen.
interface clk_tick_gen_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic [CHANNELS-1:0] en;
  logic [CHANNELS-1:0] sync;
  logic                div_wr;
  logic [SELW-1:0]     div_sel;
  logic [WIDTH-1:0]    div_data;
  logic [CHANNELS-1:0] clk_out;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] pending;

  modport master (
    output en, sync, div_wr, div_sel, div_data,
    input  clk_out, tick, pending
  );
  modport slave (
    input  en, sync, div_wr, div_sel, div_data,
    output clk_out, tick, pending
  );
endinterface

// File: rtl/clk_tick_gen.sv
// clk_tick_gen: CHANNELS independent clock dividers / tick generators.
//   clk, reset  source clock, async active-high reset
//   bus         clk_tick_gen_if.slave (enables, syncs, divisor writes in;
//               divided clocks, ticks, pending flags out)
// Each channel divides by a runtime divisor N: clk_out has period 2N, tick
// pulses once every N enabled cycles. Divisor writes land in a shadow
// register and are committed at the next wrap, or on the next idle edge.

// One divider channel. wr/wdata are already decoded and zero-mapped.
module clk_tick_lane #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] DEF   = WIDTH'(7)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);
  logic [WIDTH-1:0] cnt, act, shd;
  logic             wrap;

  // act is never 0, so act-1 cannot underflow.
  assign wrap = (cnt == act - WIDTH'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      act     <= DEF;
      shd     <= DEF;
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (sync) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (en) begin
        if (wrap) begin
          cnt     <= '0;
          clk_out <= ~clk_out;
          tick    <= 1'b1;
          if (pending) begin
            act     <= shd;
            pending <= 1'b0;
          end
        end else begin
          cnt  <= cnt + WIDTH'(1);
          tick <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
        // Idle commit: restart the count under the new divisor.
        if (pending) begin
          act     <= shd;
          cnt     <= '0;
          pending <= 1'b0;
        end
      end
      // A write in a commit cycle: commit used the old shd above, the new
      // value stays pending (later assignment wins).
      if (wr) begin
        shd     <= wdata;
        pending <= 1'b1;
      end
    end
  end
endmodule

module clk_tick_gen #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 7,
  parameter int SELW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic           clk,
  input  logic           reset,
  clk_tick_gen_if.slave  bus
);
  logic [WIDTH-1:0]    wdata;
  logic [CHANNELS-1:0] clk_out_w, tick_w, pend_w;

  // Divisor 0 is meaningless; store it as 1.
  assign wdata = (bus.div_data == '0) ? WIDTH'(1) : bus.div_data;

  // div_sel >= CHANNELS matches no lane, so such writes are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    clk_tick_lane #(
      .WIDTH (WIDTH),
      .DEF   (WIDTH'(DEFAULT_DIV))
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .en      (bus.en[i]),
      .sync    (bus.sync[i]),
      .wr      (bus.div_wr && (bus.div_sel == SELW'(i))),
      .wdata   (wdata),
      .clk_out (clk_out_w[i]),
      .tick    (tick_w[i]),
      .pending (pend_w[i])
    );
  end

  assign bus.clk_out = clk_out_w;
  assign bus.tick    = tick_w;
  assign bus.pending = pend_w;
endmodule

// File: tb/tb_clk_tick_gen.sv
// Directed bench for clk_tick_gen (3 channels so div_sel=3 is out of range).
// Edge numbering restarts at 0 after each reset; step_chk advances one edge
// and compares tick/clk_out of one channel against a hand-listed wrap schedule.
module tb_clk_tick_gen;
  localparam int CH = 3, W = 16, SW = 2;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  clk_tick_gen_if #(.CHANNELS(CH), .WIDTH(W), .SELW(SW)) bus ();

  clk_tick_gen #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(7), .SELW(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_chk = 0, n_err = 0;
  int   e;
  int   wraps[$];
  logic exp_clk, exp_tick;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.en = '0; bus.sync = '0; bus.div_wr = 1'b0; bus.div_sel = '0; bus.div_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    reset = 1'b0;
    e = 0; exp_clk = 1'b0; exp_tick = 1'b0;
  endtask

  task automatic wr(input int sel, input int data);
    bus.div_wr = 1'b1; bus.div_sel = SW'(sel); bus.div_data = W'(data);
  endtask

  task automatic step_chk(input int ch);
    @(posedge clk); #1;
    e++;
    exp_tick = 1'b0;
    foreach (wraps[k]) if (wraps[k] == e) exp_tick = 1'b1;
    if (exp_tick) exp_clk = ~exp_clk;
    chk($sformatf("e%0d_tick%0d", e, ch), bus.tick[ch], exp_tick);
    chk($sformatf("e%0d_clk%0d", e, ch), bus.clk_out[ch], exp_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    drive_idle();
    // 1: reset state, then default divisor 7 on ch0.
    do_reset();
    chk("rst_clk", bus.clk_out, 0);
    chk("rst_tick", bus.tick, 0);
    chk("rst_pend", bus.pending, 0);
    bus.en = 3'b001;
    wraps = '{7, 14, 21, 28};
    repeat (28) step_chk(0);

    // 2: ch1 rewritten to 3 mid-period; current period stays 7.
    do_reset();
    bus.en = 3'b010;
    wraps = '{7, 10, 13, 16};
    repeat (3) step_chk(1);
    wr(1, 3);
    step_chk(1);
    bus.div_wr = 1'b0;
    chk("t2_pend_e4", bus.pending, 3'b010);
    repeat (2) step_chk(1);
    chk("t2_pend_e6", bus.pending, 3'b010);
    step_chk(1);
    chk("t2_pend_e7", bus.pending, 0);
    repeat (9) step_chk(1);

    // 3: divisor 0 on idle ch2 -> idle commit of 1, then clk/2 with tick stuck high.
    do_reset();
    wraps = '{3, 4, 5, 6, 7, 8};
    wr(2, 0);
    step_chk(2);
    bus.div_wr = 1'b0;
    chk("t3_pend_e1", bus.pending, 3'b100);
    step_chk(2);
    chk("t3_pend_e2", bus.pending, 0);
    bus.en = 3'b100;
    repeat (6) step_chk(2);

    // 4: ch0 writes 5 then 9 before wrap; 4 written in the wrap cycle.
    do_reset();
    bus.en = 3'b001;
    wraps = '{7, 16, 20, 24};
    step_chk(0);
    wr(0, 5);
    step_chk(0);
    chk("t4_pend_e2", bus.pending, 3'b001);
    wr(0, 9);
    step_chk(0);
    bus.div_wr = 1'b0;
    repeat (3) step_chk(0);
    wr(0, 4);
    step_chk(0);
    bus.div_wr = 1'b0;
    chk("t4_pend_e7", bus.pending, 3'b001);
    repeat (8) step_chk(0);
    chk("t4_pend_e15", bus.pending, 3'b001);
    step_chk(0);
    chk("t4_pend_e16", bus.pending, 0);
    repeat (8) step_chk(0);

    // 5: ch0/ch1 offset in phase, then synced together; out-of-range write.
    do_reset();
    wraps = '{13, 20, 27};
    bus.en = 3'b001;
    repeat (3) step_chk(0);
    bus.en = 3'b011;
    repeat (2) step_chk(0);
    bus.sync = 3'b011;
    step_chk(0);
    bus.sync = 3'b000;
    chk("t5_clk1_sync", bus.clk_out[1], 0);
    step_chk(0);
    wr(3, 2);
    for (int k = 0; k < 20; k++) begin
      step_chk(0);
      bus.div_wr = 1'b0;
      chk($sformatf("e%0d_clk1", e), bus.clk_out[1], exp_clk);
      chk($sformatf("e%0d_tick1", e), bus.tick[1], exp_tick);
      if (k == 0) chk("t5_badsel_pend", bus.pending, 0);
    end

    // 6: async reset mid-period with a pending write.
    do_reset();
    bus.en = 3'b001;
    wraps = '{7};
    repeat (10) step_chk(0);
    wr(0, 3);
    step_chk(0);
    bus.div_wr = 1'b0;
    chk("t6_pend_pre", bus.pending, 3'b001);
    chk("t6_clk_pre", bus.clk_out, 3'b001);
    #2 reset = 1'b1;
    #1;
    chk("t6_clk_async", bus.clk_out, 0);
    chk("t6_tick_async", bus.tick, 0);
    chk("t6_pend_async", bus.pending, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    e = 0; exp_clk = 1'b0;
    chk("t6_pend_post", bus.pending, 0);
    wraps = '{7, 14};
    repeat (14) step_chk(0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/clk_tick_gen.md
# clk_tick_gen

Parametrised multi-channel clock divider and tick generator. It replaces the single fixed-divisor toggle divider that drives the processor clock. Each channel has a runtime-reloadable divisor, an enable, and a phase-align clear. Each channel produces both a 50%-duty divided clock and a single-cycle tick enable. It sits between the board clock and the processor, key scanner and game-timing logic.

## Interface
- CHANNELS, 4, number of independent divider channels (1..16)
- WIDTH, 16, divisor and counter width in bits
- DEFAULT_DIV, 7, divisor loaded into every channel at reset (1..2^WIDTH-1)
- SELW, $clog2(CHANNELS) (min 1), width of div_sel
---
- clk  in  1  source clock
- reset  in  1  asynchronous, active-high; clock clk
- en  in  CHANNELS  per-channel count enable
- sync  in  CHANNELS  per-channel synchronous phase clear
- div_wr  in  1  divisor write strobe
- div_sel  in  SELW  channel index for div_wr
- div_data  in  WIDTH  new divisor N
- clk_out  out  CHANNELS  divided clocks, period 2N cycles of clk
- tick  out  CHANNELS  one-cycle pulse every N enabled cycles
- pending  out  CHANNELS  shadow divisor not yet committed

## Operation
- Per-channel state:
  - counter cnt[WIDTH]
  - active divisor act[WIDTH]
  - shadow divisor shd[WIDTH]
  - pending flag
  - clk_out register
  - tick register
- Reset (async): cnt=0, act=shd=DEFAULT_DIV, pending=0, clk_out=0, tick=0.
- Per-channel priority each edge: sync > wrap/count > idle commit.
- sync[i]=1: cnt<=0, clk_out<=0, tick<=0. act, shd and pending are untouched.
- en[i]=1, sync[i]=0:
  - If cnt==act-1 (wrap): cnt<=0, clk_out toggles, tick<=1. If pending, act<=shd and pending<=0.
  - Otherwise: cnt<=cnt+1, tick<=0.
- en[i]=0, sync[i]=0:
  - cnt and clk_out hold; tick<=0.
  - If pending: act<=shd, cnt<=0, pending<=0 (idle commit).
- Write: div_wr=1 with div_sel<CHANNELS loads shd[div_sel] and sets pending.
  - div_data==0 is stored as 1.
  - div_sel>=CHANNELS: write ignored.
  - A write to an already-pending channel overwrites shd; only the last value commits.
- Write in the same cycle as a wrap on the same channel: the wrap commits the old shd (if pending), and the new value is captured with pending left at 1.
- Arithmetic: compare is cnt==act-1 in WIDTH bits. act>=1 always holds, so there is no underflow. cnt never exceeds act-1.
- N=1: wrap on every enabled cycle. clk_out toggles every cycle (clk/2) and tick stays high continuously while en=1.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Divisor write sampled at edge t: pending=1 after edge t.
- Counting, with en high continuously from edge 1:
  - First wrap at edge N: clk_out rises and tick is high for the cycle following edge N.
  - Subsequent wraps at edges 2N, 3N, ...
  - clk_out high time and low time are each N clk cycles.
- Divisor change while counting: the new divisor takes effect for the period starting after the next wrap. There are no glitches or truncated half-periods.
- Divisor change while idle: committed one edge after the write if en stays low.
- sync: the first wrap after sync occurs N enabled edges after the sync edge.
- Reset mid-operation: all outputs return to their reset values immediately, and a pending write is lost.

## Test plan
- Reset, DEFAULT_DIV=7, en[0]=1 -> clk_out[0] period 14 clk (7 high, 7 low); tick[0] is one cycle wide every 7 cycles; the first tick follows edge 7.
- Write ch1 div_data=3 while counting with act=7, mid-period -> pending[1]=1 until the next wrap. The current half-period stays 7; later half-periods are 3 and ticks come every 3 cycles.
- div_data=0 on ch2 with en[2] low -> pending[2] clears after one edge and act=1. Then en[2]=1 gives clk_out[2] toggling every cycle with tick[2] constant high.
- Two writes to ch0 (5 then 9) before the next wrap, and a write in the exact wrap cycle -> only 9 commits; the same-cycle write stays pending for the following wrap.
- sync[0] and sync[1] pulsed together on channels with equal divisors -> clk_out[0] and clk_out[1] are phase-identical afterwards. div_sel=CHANNELS produces no state change.
- Async reset asserted mid-period with a pending write -> all outputs are 0 immediately. After release, act=DEFAULT_DIV and pending=0.
